// File: rtl/controle_multiciclo_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller:
// FSM states, ALU operation codes, opcodes and datapath mux selects.
package controle_pkg;

    typedef enum logic [3:0] {
        ST_RESET,
        ST_FETCH,
        ST_LOAD_IR,
        ST_DECODE,
        ST_EXEC,
        ST_ALU_WB,
        ST_ADDR,
        ST_MEM_RD,
        ST_LOAD_WB,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JAL,
        ST_LUI,
        ST_ERROR
    } estado_t;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic       SRC_A_PC     = 1'b0;
    localparam logic       SRC_A_RS1    = 1'b1;
    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_CONST4 = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;
    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;
    localparam logic [1:0] M2R_IMM    = 2'b11;

    // Counter width able to hold max_val, never narrower than one bit.
    function automatic int largura(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath bundle: instruction fields and flags in,
// register enables, memory strobes and mux selects out.
interface controle_multiciclo_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       reset_wire;
    logic       WRITE_PC;
    logic       WRITE_INSTRUCTION;
    logic       WRITE_REG;
    logic       WRITE_ALUOUT;
    logic       WR_MEM_INSTR;
    logic       RD_MEM_DATA;
    logic       WR_MEM_DATA;
    logic [2:0] operacao;
    logic       ALU_SRC_A;
    logic [1:0] ALU_SRC_B;
    logic       PC_SRC;
    logic [1:0] MEM_TO_REG;
    logic       erro;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output reset_wire, WRITE_PC, WRITE_INSTRUCTION, WRITE_REG, WRITE_ALUOUT,
               WR_MEM_INSTR, RD_MEM_DATA, WR_MEM_DATA, operacao,
               ALU_SRC_A, ALU_SRC_B, PC_SRC, MEM_TO_REG, erro
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  reset_wire, WRITE_PC, WRITE_INSTRUCTION, WRITE_REG, WRITE_ALUOUT,
               WR_MEM_INSTR, RD_MEM_DATA, WR_MEM_DATA, operacao,
               ALU_SRC_A, ALU_SRC_B, PC_SRC, MEM_TO_REG, erro
    );

endinterface

// File: rtl/contador_espera.sv
// Loadable down-counter that stops at zero and flags it; used for both
// the instruction-fetch wait and the data-memory timeout.
module contador_espera #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_valor,
    input  logic             i_dec,
    output logic             o_fim
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_valor;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_fim = (r_count == '0);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V control unit: Moore-decoded FSM with a Mealy branch
// enable, bounded instruction-fetch wait and data-memory timeout.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int FETCH_WAIT  = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    controle_multiciclo_if.master ctl
);

    localparam int W_FETCH = largura(FETCH_WAIT);
    localparam int W_MEM   = largura(MEM_TIMEOUT - 1);
    localparam logic [W_FETCH-1:0] FETCH_CARGA = W_FETCH'(FETCH_WAIT);
    localparam logic [W_MEM-1:0]   MEM_CARGA   = W_MEM'(MEM_TIMEOUT - 1);

    estado_t r_state;
    estado_t w_next;
    logic    w_fetch_fim;
    logic    w_mem_fim;
    logic    w_fetch_load;
    logic    w_mem_load;
    logic    w_mem_dec;
    logic    w_rtype;
    logic    w_taken;

    assign w_fetch_load = (w_next == ST_FETCH) && (r_state != ST_FETCH);
    assign w_mem_load   = (r_state == ST_ADDR);
    assign w_mem_dec    = (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);
    assign w_rtype      = (ctl.opcode == OP_R);
    assign w_taken      = ((ctl.funct3 == 3'b000) &&  ctl.zero) ||
                          ((ctl.funct3 == 3'b001) && !ctl.zero);

    contador_espera #(.WIDTH(W_FETCH)) u_espera_fetch (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (w_fetch_load),
        .i_valor (FETCH_CARGA),
        .i_dec   (r_state == ST_FETCH),
        .o_fim   (w_fetch_fim)
    );

    // The timeout counter is preloaded with MEM_TIMEOUT-1 so reaching zero
    // without mem_ready marks the last allowed cycle.
    contador_espera #(.WIDTH(W_MEM)) u_espera_mem (
        .clk     (CLK),
        .rst     (RST),
        .i_load  (w_mem_load),
        .i_valor (MEM_CARGA),
        .i_dec   (w_mem_dec),
        .o_fim   (w_mem_fim)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        w_next                = r_state;
        ctl.reset_wire        = 1'b0;
        ctl.WRITE_PC          = 1'b0;
        ctl.WRITE_INSTRUCTION = 1'b0;
        ctl.WRITE_REG         = 1'b0;
        ctl.WRITE_ALUOUT      = 1'b0;
        ctl.WR_MEM_INSTR      = 1'b0;
        ctl.RD_MEM_DATA       = 1'b0;
        ctl.WR_MEM_DATA       = 1'b0;
        ctl.operacao          = ALU_NOP;
        ctl.ALU_SRC_A         = SRC_A_PC;
        ctl.ALU_SRC_B         = SRC_B_RS2;
        ctl.PC_SRC            = PC_SRC_ALU;
        ctl.MEM_TO_REG        = M2R_ALUOUT;
        ctl.erro              = 1'b0;

        case (r_state)
            ST_RESET: begin
                ctl.reset_wire = 1'b1;
                w_next         = ST_FETCH;
            end
            ST_FETCH: begin
                ctl.WR_MEM_INSTR = 1'b1;
                if (w_fetch_fim) w_next = ST_LOAD_IR;
            end
            ST_LOAD_IR: begin
                ctl.WRITE_INSTRUCTION = 1'b1;
                ctl.WRITE_PC          = 1'b1;
                ctl.ALU_SRC_B         = SRC_B_CONST4;
                ctl.operacao          = ALU_ADD;
                w_next                = ST_DECODE;
            end
            ST_DECODE: begin
                ctl.ALU_SRC_B    = SRC_B_IMM;
                ctl.operacao     = ALU_ADD;
                ctl.WRITE_ALUOUT = 1'b1;
                case (ctl.opcode)
                    OP_R, OP_I:        w_next = ST_EXEC;
                    OP_LOAD, OP_STORE: w_next = ST_ADDR;
                    OP_BRANCH:         w_next = ST_BRANCH;
                    OP_JAL:            w_next = ST_JAL;
                    OP_LUI:            w_next = ST_LUI;
                    default:           w_next = ST_ERROR;
                endcase
            end
            ST_EXEC: begin
                ctl.ALU_SRC_A    = SRC_A_RS1;
                ctl.ALU_SRC_B    = w_rtype ? SRC_B_RS2 : SRC_B_IMM;
                ctl.WRITE_ALUOUT = 1'b1;
                w_next           = ST_ALU_WB;
                case (ctl.funct3)
                    3'b000:  ctl.operacao = (w_rtype && ctl.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b100:  ctl.operacao = ALU_XOR;
                    3'b110:  ctl.operacao = ALU_OR;
                    3'b111:  ctl.operacao = ALU_AND;
                    default: w_next       = ST_ERROR;
                endcase
            end
            ST_ALU_WB: begin
                ctl.WRITE_REG  = 1'b1;
                ctl.MEM_TO_REG = M2R_ALUOUT;
                w_next         = ST_FETCH;
            end
            ST_ADDR: begin
                ctl.ALU_SRC_A    = SRC_A_RS1;
                ctl.ALU_SRC_B    = SRC_B_IMM;
                ctl.operacao     = ALU_ADD;
                ctl.WRITE_ALUOUT = 1'b1;
                w_next           = (ctl.opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                ctl.RD_MEM_DATA = 1'b1;
                if (ctl.mem_ready)  w_next = ST_LOAD_WB;
                else if (w_mem_fim) w_next = ST_ERROR;
            end
            ST_LOAD_WB: begin
                ctl.WRITE_REG  = 1'b1;
                ctl.MEM_TO_REG = M2R_MDR;
                w_next         = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctl.WR_MEM_DATA = 1'b1;
                if (ctl.mem_ready)  w_next = ST_FETCH;
                else if (w_mem_fim) w_next = ST_ERROR;
            end
            ST_BRANCH: begin
                ctl.ALU_SRC_A = SRC_A_RS1;
                ctl.ALU_SRC_B = SRC_B_RS2;
                ctl.operacao  = ALU_SUB;
                ctl.WRITE_PC  = w_taken;
                ctl.PC_SRC    = w_taken ? PC_SRC_ALUOUT : PC_SRC_ALU;
                w_next        = (ctl.funct3[2:1] == 2'b00) ? ST_FETCH : ST_ERROR;
            end
            ST_JAL: begin
                ctl.WRITE_PC   = 1'b1;
                ctl.PC_SRC     = PC_SRC_ALUOUT;
                ctl.WRITE_REG  = 1'b1;
                ctl.MEM_TO_REG = M2R_PC;
                w_next         = ST_FETCH;
            end
            ST_LUI: begin
                ctl.WRITE_REG  = 1'b1;
                ctl.MEM_TO_REG = M2R_IMM;
                w_next         = ST_FETCH;
            end
            ST_ERROR: begin
                ctl.erro = 1'b1;
            end
            default: begin
                w_next = ST_ERROR;
            end
        endcase
    end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 Parameter FETCH_WAIT, default 1, meaning instruction-memory wait cycles after the fetch request cycle.
REQ-002 Parameter MEM_TIMEOUT, default 15, meaning maximum cycles spent in a data-memory state before an error is declared.
REQ-003 CLK  in  1  single clock; all state updates on posedge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  7  instruction bits [6:0] from the instruction register.
REQ-006 funct3  in  3  instruction bits [14:12].
REQ-007 funct7b5  in  1  instruction bit 30.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  data-memory access complete.
REQ-010 reset_wire  out  1  datapath register reset.
REQ-011 WRITE_PC, WRITE_INSTRUCTION, WRITE_REG, WRITE_ALUOUT  out  1 each  register write enables.
REQ-012 WR_MEM_INSTR  out  1  instruction-memory read request.
REQ-013 RD_MEM_DATA, WR_MEM_DATA  out  1 each  data-memory strobes.
REQ-014 operacao  out  3  ALU op: 000 nop, 001 add, 010 sub, 011 and, 100 or, 101 xor.
REQ-015 ALU_SRC_A  out  1 (0 PC, 1 rs1); ALU_SRC_B  out  2 (00 rs2, 01 const 4, 10 imm); PC_SRC  out  1 (0 ALU result, 1 ALUOut); MEM_TO_REG  out  2 (00 ALUOut, 01 MDR, 10 PC, 11 imm).
REQ-016 erro  out  1  sticky illegal-instruction or timeout flag.

Function
REQ-017 States: RESET, FETCH, LOAD_IR, DECODE, EXEC, ALU_WB, ADDR, MEM_RD, LOAD_WB, MEM_WR, BRANCH, JAL, LUI, ERROR; every output not listed for a state SHALL be 0.
REQ-018 RESET: reset_wire=1; next FETCH.
REQ-019 FETCH: WR_MEM_INSTR=1 for exactly FETCH_WAIT+1 cycles (down-counter loaded on entry); then LOAD_IR.
REQ-020 LOAD_IR: WRITE_INSTRUCTION=1, WRITE_PC=1, ALU_SRC_A=0, ALU_SRC_B=01, operacao=001, PC_SRC=0 (PC <- PC+4); next DECODE.
REQ-021 DECODE: ALU_SRC_A=0, ALU_SRC_B=10, operacao=001, WRITE_ALUOUT=1 (branch/jump target); next by opcode: 0110011/0010011->EXEC, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JAL, 0110111->LUI, else ERROR.
REQ-022 EXEC: ALU_SRC_A=1, ALU_SRC_B=00 for R-type or 10 for I-type, WRITE_ALUOUT=1; funct3 000->001 (010 if R-type and funct7b5=1), 100->101, 110->100, 111->011, other funct3->ERROR; next ALU_WB.
REQ-023 ALU_WB: WRITE_REG=1, MEM_TO_REG=00; next FETCH.
REQ-024 ADDR: ALU_SRC_A=1, ALU_SRC_B=10, operacao=001, WRITE_ALUOUT=1; next MEM_RD for load, MEM_WR for store.
REQ-025 MEM_RD/MEM_WR: RD_MEM_DATA/WR_MEM_DATA held 1; timeout counter cleared on entry; leave on the cycle mem_ready=1 sampled (MEM_RD->LOAD_WB, MEM_WR->FETCH); if MEM_TIMEOUT cycles elapse without mem_ready -> ERROR; mem_ready outside these states ignored.
REQ-026 LOAD_WB: WRITE_REG=1, MEM_TO_REG=01; next FETCH.
REQ-027 BRANCH: ALU_SRC_A=1, ALU_SRC_B=00, operacao=010; WRITE_PC=1, PC_SRC=1 combinationally when (funct3=000 and zero) or (funct3=001 and !zero); other funct3 -> ERROR; next FETCH.
REQ-028 JAL: WRITE_PC=1, PC_SRC=1, WRITE_REG=1, MEM_TO_REG=10; next FETCH.
REQ-029 LUI: WRITE_REG=1, MEM_TO_REG=11; next FETCH.
REQ-030 ERROR: erro=1, all strobes 0, held until RST.
REQ-031 Outputs Moore-decoded from state, except BRANCH WRITE_PC (Mealy on zero, funct3).
REQ-032 Latency at default FETCH_WAIT: ALU op 6 cycles, LUI/JAL/branch 5, load 6+n, store 5+n (n = cycles in memory state, 1..MEM_TIMEOUT).

Reset
REQ-033 RST asserted at any time, including mid-memory access, SHALL force RESET immediately, clear both counters, and drop all strobes asynchronously.
REQ-034 In RESET all outputs 0 except reset_wire=1; erro cleared.

Structure
REQ-035 Package controle_pkg SHALL hold the state enum, operacao codes, opcode constants and mux select encodings.
REQ-036 One sub-module contador_espera (loadable down-counter with terminal flag) SHALL serve both fetch wait and memory timeout.

Verification
REQ-037 RST pulse then release -> one RESET cycle with reset_wire=1, then WR_MEM_INSTR=1 for 2 cycles.
REQ-038 opcode=0110011, funct3=000, funct7b5=1 -> operacao=010 in EXEC, WRITE_REG=1 at cycle 6.
REQ-039 load, mem_ready after 3 cycles -> RD_MEM_DATA high 3 cycles, LOAD_WB with MEM_TO_REG=01.
REQ-040 beq with zero=1 -> WRITE_PC=1, PC_SRC=1; with zero=0 -> WRITE_PC=0.
REQ-041 store with mem_ready held 0 -> ERROR after 15 cycles, erro=1 until RST.
REQ-042 opcode=1111111 -> ERROR from DECODE; RST asserted mid-MEM_RD -> WR/RD strobes 0 same cycle.
